// File: rtl/crc_rr_sched.sv
// Round-robin arbiter sharing one multi-cycle CRC engine between NUM_REQ requesters.
// Each accepted word is issued to the engine and its remainder returned on a valid/ready port.
//
// state   | meaning
// S_IDLE  | searching for the next requester in round-robin order
// S_ISSUE | one-cycle engine start pulse with latched data
// S_WAIT  | waiting for engine done, timeout down-counter running
// S_RESP  | result held until consumer takes it
module crc_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 3,
  parameter int CRC_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_eng_start,
  output logic [DATA_W-1:0]         o_eng_data,
  input  logic                      i_eng_done,
  input  logic [CRC_W-1:0]          i_eng_crc,
  output logic                      o_res_valid,
  output logic [ID_W-1:0]           o_res_id,
  output logic [CRC_W-1:0]          o_res_crc,
  output logic                      o_res_err,
  input  logic                      i_res_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic              any_valid;
  logic [CNT_W-1:0]  cnt;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!any_valid && i_req_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (state == S_IDLE && any_valid) o_req_ready[grant] = 1'b1;
  end

  assign o_eng_start = (state == S_ISSUE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (i_eng_done || cnt == '0) state_nxt = S_RESP;
      S_RESP:  if (i_res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
      o_eng_data  <= '0;
      o_res_id    <= '0;
      o_res_crc   <= '0;
      o_res_err   <= 1'b0;
      o_res_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            o_eng_data <= i_req_data[grant*DATA_W +: DATA_W];
            o_res_id   <= grant;
            last_grant <= grant;
          end
        end
        S_ISSUE: cnt <= CNT_LOAD;
        S_WAIT: begin
          // Done takes priority over a coincident timeout.
          if (i_eng_done) begin
            o_res_crc   <= i_eng_crc;
            o_res_err   <= 1'b0;
            o_res_valid <= 1'b1;
          end else if (cnt == '0) begin
            o_res_crc   <= '0;
            o_res_err   <= 1'b1;
            o_res_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_res_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_rr_sched.sv
// Bench for crc_rr_sched: randomized requests against a round-robin / latency reference model,
// with a small engine responder that returns done a programmable number of cycles after start.
module tb_crc_rr_sched;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int DW = 3;
  localparam int CW = 4;
  localparam int TO = 16;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [NR-1:0]   i_req_valid = '0;
  logic [NR*DW-1:0] i_req_data = '0;
  logic            i_eng_done;
  logic [CW-1:0]   i_eng_crc = '0;
  logic            i_res_ready = 1'b0;
  logic [NR-1:0]   o_req_ready;
  logic            o_eng_start;
  logic [DW-1:0]   o_eng_data;
  logic            o_res_valid;
  logic [IW-1:0]   o_res_id;
  logic [CW-1:0]   o_res_crc;
  logic            o_res_err;

  logic            eng_done_m = 1'b0;
  logic            stray_done = 1'b0;
  int              eng_lat = -1;
  logic [CW-1:0]   eng_crc_val = '0;
  int              eng_cnt = 0;

  int checks = 0;
  int failures = 0;
  int m_last = NR - 1;

  assign i_eng_done = eng_done_m | stray_done;

  crc_rr_sched #(.NUM_REQ(NR), .ID_W(IW), .DATA_W(DW), .CRC_W(CW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_eng_start(o_eng_start), .o_eng_data(o_eng_data),
    .i_eng_done(i_eng_done), .i_eng_crc(i_eng_crc), .o_res_valid(o_res_valid),
    .o_res_id(o_res_id), .o_res_crc(o_res_crc), .o_res_err(o_res_err), .i_res_ready(i_res_ready)
  );

  always #5 i_clk = ~i_clk;

  // Engine responder: done is sampled by the DUT (2 + eng_lat) edges after the accept edge.
  always @(negedge i_clk) begin
    eng_done_m = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        eng_done_m = 1'b1;
        i_eng_crc  = eng_crc_val;
      end
    end
    if (o_eng_start === 1'b1 && eng_lat > 0) eng_cnt = eng_lat + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  function automatic int model_grant(input logic [NR-1:0] v);
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (m_last + i) % NR;
      if (v[k[IW-1:0]]) return k;
    end
    return -1;
  endfunction

  // One full transaction; expectations come from round-robin order and the latency/timeout rules.
  task automatic do_txn(input logic [NR-1:0] mask, input int lat, input logic [NR*DW-1:0] data,
                        input logic [CW-1:0] crc, input int stall);
    int g, n, eff;
    logic [NR-1:0] exp_rdy;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_crc;
    logic          exp_err;
    g = model_grant(mask);
    exp_rdy = '0;
    exp_rdy[g[IW-1:0]] = 1'b1;
    exp_data = data[g*DW +: DW];
    exp_err  = (lat < 1 || lat > TO - 1);
    eff      = exp_err ? TO - 1 : lat;
    exp_crc  = exp_err ? '0 : crc;
    i_req_data  = data;
    i_req_valid = mask;
    eng_lat     = lat;
    eng_crc_val = crc;
    i_res_ready = (stall == 0);
    #1;
    checks++;
    if (o_req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL req_ready actual=%b required=%b", o_req_ready, exp_rdy);
    end
    @(posedge i_clk); #1;
    m_last = g;
    checks++;
    if (o_eng_start !== 1'b1 || o_eng_data !== exp_data || o_req_ready !== '0) begin
      failures++;
      $display("FAIL issue actual start=%b data=%b ready=%b required start=1 data=%b ready=0",
               o_eng_start, o_eng_data, o_req_ready, exp_data);
    end
    n = 0;
    while (o_res_valid !== 1'b1 && n < 64) begin
      @(posedge i_clk); #1;
      n++;
      if (o_res_valid !== 1'b1) begin
        checks++;
        if (o_req_ready !== '0 || o_eng_start !== 1'b0 || o_eng_data !== exp_data) begin
          failures++;
          $display("FAIL wait_quiet actual ready=%b start=%b data=%b required ready=0 start=0 data=%b",
                   o_req_ready, o_eng_start, o_eng_data, exp_data);
        end
      end
    end
    checks++;
    if (n != 2 + eff) begin
      failures++;
      $display("FAIL latency actual=%0d required=%0d", n, 2 + eff);
    end
    checks++;
    if (o_res_id !== g[IW-1:0] || o_res_crc !== exp_crc || o_res_err !== exp_err) begin
      failures++;
      $display("FAIL result actual id=%0d crc=%b err=%b required id=%0d crc=%b err=%b",
               o_res_id, o_res_crc, o_res_err, g, exp_crc, exp_err);
    end
    for (int s = 0; s < stall; s++) begin
      i_req_valid = '1;
      @(posedge i_clk); #1;
      checks++;
      if (o_res_valid !== 1'b1 || o_res_id !== g[IW-1:0] || o_res_crc !== exp_crc ||
          o_res_err !== exp_err || o_req_ready !== '0) begin
        failures++;
        $display("FAIL stall_hold actual v=%b id=%0d crc=%b err=%b rdy=%b required v=1 id=%0d crc=%b err=%b rdy=0",
                 o_res_valid, o_res_id, o_res_crc, o_res_err, o_req_ready, g, exp_crc, exp_err);
      end
    end
    i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_res_valid !== 1'b0 || o_res_err !== 1'b0) begin
      failures++;
      $display("FAIL release actual valid=%b err=%b required valid=0 err=0", o_res_valid, o_res_err);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_req_valid = '0;
    i_res_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_req_ready !== '0 || o_eng_start !== 1'b0 || o_eng_data !== '0 || o_res_valid !== 1'b0 ||
        o_res_id !== '0 || o_res_crc !== '0 || o_res_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs actual rdy=%b st=%b d=%b v=%b id=%0d crc=%b err=%b required all 0",
               o_req_ready, o_eng_start, o_eng_data, o_res_valid, o_res_id, o_res_crc, o_res_err);
    end
    i_rst = 1'b0;
    m_last = NR - 1;
  endtask

  task automatic test_single();
    logic [NR*DW-1:0] d;
    d = NR*DW'($urandom);
    d[2*DW +: DW] = 3'b101;
    do_txn(4'b0100, 3, d, 4'b1100, 0);
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp;
    test_reset();
    for (int t = 0; t < 5; t++) begin
      i_req_valid = '1;
      #1;
      exp = '0;
      exp[t % NR] = 1'b1;
      checks++;
      if (o_req_ready !== exp) begin
        failures++;
        $display("FAIL fair_order actual=%b required=%b", o_req_ready, exp);
      end
      do_txn('1, 1, NR*DW'($urandom), CW'($urandom), 0);
    end
  endtask

  task automatic test_timeout();
    do_txn(NR'($urandom_range(1, 15)), -1, NR*DW'($urandom), CW'($urandom_range(1, 15)), 0);
    do_txn(NR'($urandom_range(1, 15)), $urandom_range(1, 5), NR*DW'($urandom), CW'($urandom), 0);
  endtask

  task automatic test_done_at_boundary();
    do_txn(NR'($urandom_range(1, 15)), TO - 1, NR*DW'($urandom), 4'b0110, 0);
  endtask

  task automatic test_stall();
    logic [NR-1:0] exp;
    do_txn(NR'($urandom_range(1, 15)), $urandom_range(1, 4), NR*DW'($urandom), CW'($urandom), 10);
    exp = '0;
    exp[model_grant('1)] = 1'b1;
    checks++;
    if (o_req_ready !== exp) begin
      failures++;
      $display("FAIL stall_next_grant actual=%b required=%b", o_req_ready, exp);
    end
    i_req_valid = '0;
  endtask

  task automatic test_stray_done();
    i_req_valid = '0;
    stray_done = 1'b1;
    @(posedge i_clk); #1;
    stray_done = 1'b0;
    checks++;
    if (o_res_valid !== 1'b0 || o_eng_start !== 1'b0 || o_req_ready !== '0) begin
      failures++;
      $display("FAIL stray_done actual v=%b st=%b rdy=%b required 0", o_res_valid, o_eng_start, o_req_ready);
    end
    do_txn(NR'($urandom_range(1, 15)), $urandom_range(1, 4), NR*DW'($urandom), CW'($urandom), 0);
  endtask

  task automatic test_reset_mid_wait();
    i_req_valid = NR'($urandom_range(1, 15));
    i_req_data  = NR*DW'($urandom);
    eng_lat = -1;
    i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = '0;
    repeat (4) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_last = NR - 1;
    checks++;
    if (o_req_ready !== '0 || o_eng_start !== 1'b0 || o_eng_data !== '0 || o_res_valid !== 1'b0 ||
        o_res_id !== '0 || o_res_crc !== '0 || o_res_err !== 1'b0) begin
      failures++;
      $display("FAIL midwait_reset actual rdy=%b st=%b d=%b v=%b id=%0d crc=%b err=%b required all 0",
               o_req_ready, o_eng_start, o_eng_data, o_res_valid, o_res_id, o_res_crc, o_res_err);
    end
    stray_done = 1'b1;
    @(posedge i_clk); #1;
    stray_done = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_res_valid !== 1'b0 || o_eng_start !== 1'b0) begin
      failures++;
      $display("FAIL late_done actual v=%b st=%b required v=0 st=0", o_res_valid, o_eng_start);
    end
    i_req_valid = '1;
    #1;
    checks++;
    if (o_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_grant actual=%b required=0001", o_req_ready);
    end
    do_txn('1, $urandom_range(1, 4), NR*DW'($urandom), CW'($urandom), 0);
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 20; t++) begin
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 8));
      do_txn(NR'($urandom_range(1, 15)), lat, NR*DW'($urandom), CW'($urandom),
             $urandom_range(0, 2));
    end
    i_req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_done_at_boundary();
    test_stall();
    test_stray_done();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
